// File: rtl/jt12_sdm_pkg.sv
// Shared constants for the multi-channel sigma-delta DAC modulator.
package jt12_sdm_pkg;

  // Accumulator width: input width plus headroom for the doubled error term.
  function automatic int unsigned ACCW(input int unsigned width);
    return width + 3;
  endfunction

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // order2 input encoding.
  localparam logic ORD1 = 1'b0;
  localparam logic ORD2 = 1'b1;

endpackage

// File: rtl/jt12_sdm_ch.sv
// One modulator channel: input ramp, first/second-order error feedback and
// 1-bit quantiser. All state advances on cen_i; captures happen on any edge.
module jt12_sdm_ch
  import jt12_sdm_pkg::*;
#(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned INTERP_SH = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cen_i,
  input  logic             order2_i,
  input  logic             din_valid_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             dith_i,
  output logic             dout_o,
  output logic             busy_o
);

  localparam int unsigned AW = ACCW(WIDTH);
  localparam int unsigned CW = INTERP_SH + 1;
  localparam logic [CW-1:0] RAMP_LEN = CW'(2 ** INTERP_SH);
  localparam logic signed [AW-1:0] HALF = AW'(2 ** (WIDTH - 1));
  localparam logic signed [AW-1:0] FULL = AW'(2 ** WIDTH);

  logic signed [WIDTH-1:0] cur_q, cur_d;
  logic signed [WIDTH-1:0] target_q, target_d;
  logic signed [WIDTH:0]   step_q, step_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [AW-1:0]    e1_q, e1_d;
  logic signed [AW-1:0]    e2_q, e2_d;
  logic                    dout_q, dout_d;

  logic signed [WIDTH:0]   diff;
  logic signed [WIDTH+1:0] sum;
  logic signed [AW-1:0]    xu, dv, v, e;
  logic                    q;

  // Ramp and capture.
  always_comb begin
    cur_d    = cur_q;
    target_d = target_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    diff     = {din_i[WIDTH-1], din_i} - {cur_q[WIDTH-1], cur_q};
    sum      = {{2{cur_q[WIDTH-1]}}, cur_q} + {step_q[WIDTH], step_q};
    if (din_valid_i) begin
      target_d = din_i;
      if (INTERP_SH == 0) begin
        cur_d = din_i;
      end else begin
        step_d = diff >>> INTERP_SH;
        cnt_d  = RAMP_LEN;
      end
    end else if (cen_i && (cnt_q > CW'(1))) begin
      // Floor rounding of a negative step can overshoot; clamp to the input range.
      if (!sum[WIDTH+1] && (sum[WIDTH:WIDTH-1] != 2'b00)) begin
        cur_d = {1'b0, {(WIDTH - 1){1'b1}}};
      end else if (sum[WIDTH+1] && (sum[WIDTH:WIDTH-1] != 2'b11)) begin
        cur_d = {1'b1, {(WIDTH - 1){1'b0}}};
      end else begin
        cur_d = sum[WIDTH-1:0];
      end
      cnt_d = cnt_q - CW'(1);
    end else if (cen_i && (cnt_q == CW'(1))) begin
      cur_d = target_q;
      cnt_d = '0;
    end
  end

  // Modulator: offset-binary input, error feedback, threshold at mid-scale.
  always_comb begin
    xu = AW'({~cur_q[WIDTH-1], cur_q[WIDTH-2:0]});
    dv = AW'(dith_i);
    if (order2_i == ORD2) begin
      v = xu + (e1_q <<< 1) - e2_q + dv;
    end else begin
      v = xu + e1_q + dv;
    end
    q = (v >= HALF);
    e = q ? (v - FULL) : v;

    dout_d = dout_q;
    e1_d   = e1_q;
    e2_d   = e2_q;
    if (cen_i) begin
      dout_d = q;
      e2_d   = e1_q;
      e1_d   = e;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cur_q    <= '0;
      target_q <= '0;
      step_q   <= '0;
      cnt_q    <= '0;
      e1_q     <= '0;
      e2_q     <= '0;
      dout_q   <= 1'b0;
    end else begin
      cur_q    <= cur_d;
      target_q <= target_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      e1_q     <= e1_d;
      e2_q     <= e2_d;
      dout_q   <= dout_d;
    end
  end

  assign dout_o = dout_q;
  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/jt12_sdm_mc.sv
// Multi-channel sigma-delta DAC modulator top: per-channel instances plus
// shared dither LFSR, enabled by defining JT12_SDM_DITHER_EN.
module jt12_sdm_mc
  import jt12_sdm_pkg::*;
#(
  parameter int unsigned CH        = 2,
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned INTERP_SH = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cen,
  input  logic                order2,
  input  logic                din_valid,
  input  logic [CH*WIDTH-1:0] din,
  output logic [CH-1:0]       dout,
  output logic                busy
);

  logic [CH-1:0] busy_ch;
  logic [CH-1:0] dith_ch;

`ifdef JT12_SDM_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (cen) begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  for (genvar k = 0; k < CH; k++) begin : g_dith
    assign dith_ch[k] = lfsr_q[k % 16];
  end
`else
  assign dith_ch = '0;
`endif

  for (genvar k = 0; k < CH; k++) begin : g_ch
    jt12_sdm_ch #(
      .WIDTH    (WIDTH),
      .INTERP_SH(INTERP_SH)
    ) u_ch (
      .clk_i      (clk),
      .rst_i      (rst),
      .cen_i      (cen),
      .order2_i   (order2),
      .din_valid_i(din_valid),
      .din_i      (din[k*WIDTH +: WIDTH]),
      .dith_i     (dith_ch[k]),
      .dout_o     (dout[k]),
      .busy_o     (busy_ch[k])
    );
  end

  assign busy = |busy_ch;

endmodule

// File: doc/jt12_sdm_mc.md
Name: jt12_sdm_mc

Overview:
- Parametrised multi-channel sigma-delta DAC modulator. Successor to the fixed second-order single-channel DAC.
- Channel count, input width and input-ramp length are parameters. Order (1 or 2) is selectable at run time.
- Each channel converts a signed PCM sample to a 1-bit density stream that feeds the pad or the sinc decimation chain.
- Sits after the FM/PSG mixer and advances only on clock-enable ticks.

Parameters:
- CH, 2, number of independent channels
- WIDTH, 12, signed input sample width
- INTERP_SH, 0, log2 of ramp length in cen ticks; 0 = new samples load immediately

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cen  in  1  clock enable; modulator and ramp advance only when high
- order2  in  1  0 = first-order, 1 = second-order error feedback
- din_valid  in  1  strobe; din is captured on any clk edge where it is high, regardless of cen
- din  in  CH*WIDTH  signed samples; channel k is at bits [k*WIDTH +: WIDTH]
- dout  out  CH  1-bit density outputs
- busy  out  1  ramp in progress on any channel

Behaviour:
- Reset, asynchronous: dout=0, busy=0. All cur, target, step, e1, e2 and ramp counters clear to 0.
- Capture:
  - din_valid=1 loads target[k]=din[k].
  - If INTERP_SH=0: cur[k] loads din[k] directly; busy stays 0.
  - If INTERP_SH>0:
    - step[k] = (din[k] - cur[k]) >>> INTERP_SH. Use arithmetic shift on a WIDTH+1 signed difference.
    - The ramp counter loads 2^INTERP_SH and busy=1.
- Ramp, on each cen with counter > 1: cur += step and the counter decrements.
- Ramp end, on the cen where counter = 1: cur = target exactly (removes truncation error), counter = 0, busy = 0.
- din_valid during a ramp: the ramp restarts from the present cur toward the new target.
- din_valid coincident with a ramp cen: the capture wins and the ramp step is discarded that cycle.
- Modulator, per channel, on each cen. Internal accumulator is WIDTH+3 signed.
  - xu = cur with its MSB inverted, zero-extended. Range 0..2^WIDTH-1.
  - v = xu + e1 when order2=0.
  - v = xu + 2*e1 - e2 when order2=1.
  - q = (v >= 2^(WIDTH-1)).
  - dout[k] <= q.
  - e = v - (q ? 2^WIDTH : 0).
  - e2 <= e1; e1 <= e.
- Latency: a sample captured at edge n drives v at the first cen after n. dout reflects that v at the same edge, i.e. one cen of latency.
- Without cen, all state holds and dout is stable.
- Long-run ones density = xu / 2^WIDTH. Accumulators never overflow for any input within the WIDTH+3 range; keep that range.
- Changing order2 takes effect on the next cen. Error registers are not cleared.
- Channels are fully independent and share only cen, order2 and din_valid.

Optional Feature:
- Macro: JT12_SDM_DITHER_EN.
- When defined:
  - A 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset, advances on each cen.
  - Bit k mod 16 is added as +1 LSB to v of channel k before quantisation.
  - Breaks idle tones; density shifts by at most 1/2^(WIDTH+1).
- When undefined: no LFSR, fully deterministic output. Test plan counts are exact for this case.

Decomposition:
- Package jt12_sdm_pkg holds:
  - accumulator width function ACCW(WIDTH)=WIDTH+3
  - LFSR seed and tap constants
  - the order encoding constants ORD1/ORD2
- Sub-module jt12_sdm_ch: one channel with its ramp, error registers and quantiser. Instantiate CH times in a generate loop.
- The top level holds din unpacking, the OR-reduction for busy, and the shared LFSR.

Test Plan:
- WIDTH=12, order2=1, din ch0=12'h100, cen always high, 4096 cen ticks after settle -> ch0 ones count = 2304 ±2.
- din ch0=-2048 (12'h800) -> dout[0]=0 constantly after 4 cen. din ch0=+2047 -> at most 1 zero per 4096 ticks.
- order2=0 with din=12'h000 -> dout alternates 1,0,1,0 in steady state. Ones count over 4096 ticks = 2048 exactly.
- INTERP_SH=3, cur=0, strobe din=12'h080:
  - busy rises at the capture edge and falls after exactly 8 cen ticks.
  - cur steps by 16 per tick and ends at 0x080.
  - Re-strobe din=0 at tick 4 -> the ramp restarts from 0x040 and reaches 0 after 8 more ticks.
- cen toggled 1-in-6 -> dout changes only on cen edges. Density matches the cen-always-high case per cen tick.
- Assert rst mid-ramp with dout=1 -> dout and busy drop asynchronously before the next clk edge. The first cen after release produces v=xu.
